// File: rtl/dff_ram_4x72_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dff_ram_4x72_fifo_ctrl
//
// Valid/ready FIFO front-end for a 4x72 single-port DFF RAM. The controller
// drives the RAM address/en/wr/wdata pins directly and captures rdata one cycle
// after each read. The RAM holds up to DEPTH words, and one more word sits in
// the registered output slot, giving DEPTH+1 entries of total storage.
//
// Ports
//   clk          rising-edge clock, shared with the RAM
//   rst_n        asynchronous active-low reset
//   in_valid     producer has a word
//   in_ready     controller accepts a word this cycle
//   in_data      producer payload
//   out_valid    output register holds a word
//   out_ready    consumer takes the word this cycle
//   out_data     registered output payload
//   count        total occupancy (RAM words + output slot), 0..DEPTH+1
//   ram_address  RAM address
//   ram_en       RAM enable, active-low
//   ram_wr       RAM direction: 0 = write, 1 = read
//   ram_wdata    RAM write data
//   ram_rdata    RAM read data, valid the cycle after a read is issued
// -----------------------------------------------------------------------------
module dff_ram_4x72_fifo_ctrl #(
  parameter int DATA_W = 72,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        count,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PEND  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              rd_issue;
  logic              wr_issue;

  // A read refills the empty output slot whenever the RAM has something.
  // Reads win over writes; the slot then spends at least two cycles in
  // PEND/VALID, so a waiting producer always gets a free cycle soon after.
  // Both issue terms are masked by rst_n so the RAM is never touched while
  // the controller is held in reset.
  assign rd_issue = rst_n && (state == S_EMPTY) && (ram_cnt != '0);
  assign in_ready = rst_n && (ram_cnt < FULL_CNT) && !rd_issue;
  assign wr_issue = in_valid && in_ready;

  // The word in flight (PEND) and the word on the output (VALID) both count
  // as occupancy, so count tracks pushes minus pops exactly.
  assign count = 3'(ram_cnt) + ((state != S_EMPTY) ? 3'd1 : 3'd0);

  // RAM pin mux. Idle cycles park the address on rd_ptr and leave en high so
  // the RAM keeps its last rdata and contents unchanged.
  always_comb begin
    ram_en      = 1'b1;
    ram_wr      = 1'b1;
    ram_address = rd_ptr;
    ram_wdata   = rst_n ? in_data : '0;
    if (rd_issue) begin
      ram_en      = 1'b0;
      ram_wr      = 1'b1;
      ram_address = rd_ptr;
    end else if (wr_issue) begin
      ram_en      = 1'b0;
      ram_wr      = 1'b0;
      ram_address = wr_ptr;
    end
  end

  // Pointer and RAM occupancy bookkeeping. Pointers wrap naturally because
  // DEPTH is a power of two. Reads and writes never coincide, so ram_cnt
  // moves by at most one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      if (wr_issue) begin
        wr_ptr  <= wr_ptr + ADDR_W'(1);
        ram_cnt <= ram_cnt + (ADDR_W + 1)'(1);
      end else if (rd_issue) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        ram_cnt <= ram_cnt - (ADDR_W + 1)'(1);
      end
    end
  end

  // Output-slot state machine. PEND lasts exactly one cycle: the RAM returns
  // the word on the cycle after the read and it is captured unconditionally.
  // out_valid is registered alongside the state and mirrors S_VALID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (rd_issue) begin
            state <= S_PEND;
          end
        end
        S_PEND: begin
          out_data  <= ram_rdata;
          out_valid <= 1'b1;
          state     <= S_VALID;
        end
        S_VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_EMPTY;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_ram_4x72_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dff_ram_4x72_fifo_ctrl
//
// Drives the FIFO controller against a behavioural 4x72 single-port RAM. The
// reference model is a plain queue of accepted words: every accepted push is
// appended, every completed pop must match the queue head, and the DUT count
// must equal the queue size.
// -----------------------------------------------------------------------------
module tb_dff_ram_4x72_fifo_ctrl;

  localparam int DATA_W = 72;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        count;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_en;
  logic              ram_wr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] q [$];
  int                checks;
  int                passes;
  int                popped;
  logic              lastFireIn;
  logic              lastFireOut;
  logic              heldValid;
  logic [DATA_W-1:0] heldData;

  dff_ram_4x72_fifo_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .ram_address(ram_address),
    .ram_en     (ram_en),
    .ram_wr     (ram_wr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: active-low enable, wr=0 writes, wr=1 reads
  // with one cycle of latency; rdata holds while the RAM is not enabled.
  always @(posedge clk) begin
    if (!ram_en) begin
      if (!ram_wr) mem[ram_address] <= ram_wdata;
      else         ram_rdata        <= mem[ram_address];
    end
  end

  // Hard stop in case a bounded loop is itself broken.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic reportFail(input string tag);
    checks++;
    $error("[TB] FAIL %s: observed timeout/underflow expected normal progress", tag);
  endtask

  // Drives one cycle of inputs, then at the falling edge checks the DUT
  // against the queue model and records which handshakes will fire.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                               input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    checkOutput("count", DATA_W'(count), DATA_W'(q.size()));
    if (!rst_n) checkOutput("ram_idle_in_reset", DATA_W'(ram_en), DATA_W'(1));
    if (q.size() == 0) checkOutput("empty_no_valid", DATA_W'(out_valid), DATA_W'(0));
    if (q.size() == DEPTH + 1) checkOutput("full_not_ready", DATA_W'(in_ready), DATA_W'(0));
    if (heldValid) begin
      checkOutput("out_valid_held", DATA_W'(out_valid), DATA_W'(1));
      checkOutput("out_data_stable", out_data, heldData);
    end
    lastFireOut = out_valid && out_ready;
    lastFireIn  = in_valid && in_ready;
    if (lastFireOut) begin
      if (q.size() == 0) reportFail("pop_underflow");
      else begin
        checkOutput("out_data_order", out_data, q[0]);
        void'(q.pop_front());
        popped++;
      end
    end
    if (lastFireIn) begin
      checkOutput("write_pins", DATA_W'({ram_en, ram_wr}), DATA_W'(0));
      checkOutput("write_data", ram_wdata, in_data);
      q.push_back(in_data);
    end
    heldValid = out_valid && !out_ready;
    heldData  = out_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic ordy);
    applyStimulus(v, d, ordy);
    tick();
  endtask

  function automatic logic [DATA_W-1:0] randWord();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  task automatic pushWord(input logic [DATA_W-1:0] d, input logic ordy, input string tag);
    for (int n = 0; n < 20; n++) begin
      cycle(1'b1, d, ordy);
      if (lastFireIn) return;
    end
    reportFail(tag);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 80 && q.size() != 0; n++) cycle(1'b0, '0, 1'b1);
    if (q.size() != 0) reportFail(tag);
  endtask

  task automatic enterReset();
    rst_n     = 1'b0;
    q.delete();
    heldValid = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] wordA;
    logic [DATA_W-1:0] wordB;
    int                startPopped;
    int                pushed;
    logic              found;

    checks    = 0;
    passes    = 0;
    popped    = 0;
    heldValid = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    enterReset();
    #12;
    checkOutput("reset_ram_en", DATA_W'(ram_en), DATA_W'(1));
    checkOutput("reset_ram_wr", DATA_W'(ram_wr), DATA_W'(1));
    checkOutput("reset_ram_addr", DATA_W'(ram_address), DATA_W'(0));
    checkOutput("reset_ram_wdata", ram_wdata, '0);
    checkOutput("reset_out_data", out_data, '0);
    tick();
    rst_n = 1'b1;

    $display("[TB] idle after reset");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, randWord(), 1'b0);
      checkOutput("idle_out_valid", DATA_W'(out_valid), DATA_W'(0));
      checkOutput("idle_in_ready", DATA_W'(in_ready), DATA_W'(1));
      checkOutput("idle_ram_en", DATA_W'(ram_en), DATA_W'(1));
      tick();
    end

    $display("[TB] two pushes, latency to first out_valid");
    wordA = {8'h0A, 64'h0123_4567_89AB_CDEF};
    wordB = {8'h0B, 64'hFEDC_BA98_7654_3210};
    applyStimulus(1'b1, wordA, 1'b1);
    checkOutput("first_push_ready", DATA_W'(in_ready), DATA_W'(1));
    tick();
    applyStimulus(1'b1, wordB, 1'b1);
    checkOutput("lat_n1_out_valid", DATA_W'(out_valid), DATA_W'(0));
    checkOutput("lat_n1_read_issue", DATA_W'({ram_en, ram_wr}), DATA_W'(2'b01));
    checkOutput("lat_n1_in_ready", DATA_W'(in_ready), DATA_W'(0));
    tick();
    applyStimulus(1'b1, wordB, 1'b1);
    checkOutput("lat_n2_out_valid", DATA_W'(out_valid), DATA_W'(0));
    tick();
    if (!lastFireIn) pushWord(wordB, 1'b1, "push_b_timeout");
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_n3_out_valid", DATA_W'(out_valid), DATA_W'(1));
    checkOutput("lat_n3_out_data", out_data, wordA);
    tick();
    drain("drain_two_timeout");
    checkOutput("two_words_popped", DATA_W'(popped), DATA_W'(2));

    $display("[TB] fill to full, then pop all");
    for (int i = 0; i < 5; i++) pushWord(randWord(), 1'b0, "fill_timeout");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, randWord(), 1'b0);
      checkOutput("sixth_rejected", DATA_W'(in_ready), DATA_W'(0));
      tick();
    end
    checkOutput("count_full", DATA_W'(count), DATA_W'(5));
    startPopped = popped;
    drain("drain_full_timeout");
    checkOutput("full_popped", DATA_W'(popped - startPopped), DATA_W'(5));
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("count_after_drain", DATA_W'(count), DATA_W'(0));
    tick();

    $display("[TB] continuous stream of 10 words");
    startPopped = popped;
    pushed      = 0;
    wordA       = randWord();
    for (int n = 0; n < 200 && (pushed < 10 || q.size() != 0); n++) begin
      cycle(pushed < 10, wordA, 1'b1);
      if (lastFireIn) begin
        pushed++;
        wordA = randWord();
      end
    end
    checkOutput("stream_pushed", DATA_W'(pushed), DATA_W'(10));
    checkOutput("stream_popped", DATA_W'(popped - startPopped), DATA_W'(10));

    $display("[TB] simultaneous push and pop in output-valid state");
    pushWord(randWord(), 1'b0, "simul_push1_timeout");
    pushWord(randWord(), 1'b0, "simul_push2_timeout");
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      applyStimulus(1'b0, '0, 1'b0);
      found = out_valid;
      tick();
    end
    if (!found) reportFail("simul_valid_timeout");
    applyStimulus(1'b1, randWord(), 1'b1);
    checkOutput("simul_in_ready", DATA_W'(in_ready), DATA_W'(1));
    checkOutput("simul_write_issue", DATA_W'({ram_en, ram_wr}), DATA_W'(2'b00));
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("simul_count", DATA_W'(count), DATA_W'(2));
    tick();
    drain("drain_simul_timeout");

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)), randWord(), 1'($urandom_range(0, 1)));
    end
    drain("drain_random_timeout");

    $display("[TB] reset while a read is pending");
    for (int i = 0; i < 4; i++) pushWord(randWord(), 1'b0, "pre_reset_push_timeout");
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      applyStimulus(1'b0, '0, 1'b0);
      found = out_valid;
      tick();
    end
    if (!found) reportFail("pre_reset_valid_timeout");
    cycle(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pre_reset_read_issue", DATA_W'({ram_en, ram_wr}), DATA_W'(2'b01));
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pre_reset_count", DATA_W'(count), DATA_W'(3));
    enterReset();
    #1;
    checkOutput("rst_out_valid", DATA_W'(out_valid), DATA_W'(0));
    checkOutput("rst_count", DATA_W'(count), DATA_W'(0));
    checkOutput("rst_ram_en", DATA_W'(ram_en), DATA_W'(1));
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, randWord(), 1'b0);
      checkOutput("rst_in_ready", DATA_W'(in_ready), DATA_W'(0));
      tick();
    end
    rst_n = 1'b1;
    wordB = randWord();
    startPopped = popped;
    pushWord(wordB, 1'b1, "post_reset_push_timeout");
    drain("post_reset_drain_timeout");
    checkOutput("post_reset_popped", DATA_W'(popped - startPopped), DATA_W'(1));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_reset_empty", DATA_W'(out_valid), DATA_W'(0));
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
